arb3_rr_sel: RTL and testbench



---
 rtl/arb3_rr_sel.sv | 125 ++++++++++++
 tb/tb_arb3_rr_sel.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/arb3_rr_sel.sv
// arb3_rr_sel: three-source round-robin arbiter feeding a registered one-hot
// AND-OR select stage. out_valid/out_data/sel come straight from flops so the
// downstream AOI222 columns see glitch-free selects; only *_ready are combinational.
module arb3_rr_sel #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             CK,
    input  logic             RST,
    input  logic             a_valid,
    input  logic [WIDTH-1:0] a_data,
    output logic             a_ready,
    input  logic             b_valid,
    input  logic [WIDTH-1:0] b_data,
    output logic             b_ready,
    input  logic             c_valid,
    input  logic [WIDTH-1:0] c_data,
    output logic             c_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready,
    output logic [2:0]       sel
);

    localparam int unsigned NSRC = 3;

    // Last-grant pointer; C after reset so A gets first priority.
    typedef enum logic [1:0] {
        PTR_A = 2'd0,
        PTR_B = 2'd1,
        PTR_C = 2'd2
    } ptr_e;

    ptr_e             last_q;
    ptr_e             last_d;
    logic             out_valid_d;
    logic [WIDTH-1:0] out_data_d;
    logic [2:0]       sel_d;

    logic [NSRC-1:0]  req;
    logic [NSRC-1:0]  grant;
    logic             room;
    logic             load;
    ptr_e             winner;

    assign req = {c_valid, b_valid, a_valid};

    // Output register can accept a word when empty or being drained this cycle;
    // nothing is acknowledged while reset is asserted.
    always_comb begin
        room = !out_valid || out_ready;
        load = room && (|req) && !RST;
    end

    // Rotating fixed-order grant: the source after the last winner comes first.
    always_comb begin
        grant = '0;
        case (last_q)
            PTR_A: begin
                if (req[1])      grant = 3'b010;
                else if (req[2]) grant = 3'b100;
                else if (req[0]) grant = 3'b001;
            end
            PTR_B: begin
                if (req[2])      grant = 3'b100;
                else if (req[0]) grant = 3'b001;
                else if (req[1]) grant = 3'b010;
            end
            default: begin
                if (req[0])      grant = 3'b001;
                else if (req[1]) grant = 3'b010;
                else if (req[2]) grant = 3'b100;
            end
        endcase
    end

    // Encode the one-hot grant back into a pointer value.
    always_comb begin
        winner = last_q;
        if (grant[0])      winner = PTR_A;
        else if (grant[1]) winner = PTR_B;
        else if (grant[2]) winner = PTR_C;
    end

    // Acknowledge only the granted source, and only when the word is taken.
    always_comb begin
        a_ready = load && grant[0];
        b_ready = load && grant[1];
        c_ready = load && grant[2];
    end

    // Next-state: load the AND-OR selected word, drain to empty, or hold.
    always_comb begin
        out_valid_d = out_valid;
        out_data_d  = out_data;
        sel_d       = sel;
        last_d      = last_q;
        if (load) begin
            out_data_d  = ({WIDTH{grant[0]}} & a_data)
                        | ({WIDTH{grant[1]}} & b_data)
                        | ({WIDTH{grant[2]}} & c_data);
            sel_d       = {grant[2], grant[1], grant[0]};
            out_valid_d = 1'b1;
            last_d      = winner;
        end else if (out_valid && out_ready) begin
            out_valid_d = 1'b0;
            sel_d       = 3'b000;
        end
    end

    // State register with synchronous active-high reset.
    always_ff @(posedge CK) begin
        if (RST) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            sel       <= 3'b000;
            last_q    <= PTR_C;
        end else begin
            out_valid <= out_valid_d;
            out_data  <= out_data_d;
            sel       <= sel_d;
            last_q    <= last_d;
        end
    end

endmodule

// File: tb/tb_arb3_rr_sel.sv
// Self-checking bench for arb3_rr_sel: directed scenarios followed by random
// traffic, all compared against a behavioural round-robin model.
module tb_arb3_rr_sel;

    localparam int unsigned WIDTH = 8;

    logic             CK;
    logic             RST;
    logic             a_valid, b_valid, c_valid;
    logic [WIDTH-1:0] a_data, b_data, c_data;
    logic             a_ready, b_ready, c_ready;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic             out_ready;
    logic [2:0]       sel;

    int total = 0;
    int bad   = 0;

    // Reference model state: held word, its source index, last winner index.
    logic             m_valid;
    logic [WIDTH-1:0] m_data;
    int               m_src;
    int               m_last;

    arb3_rr_sel #(.WIDTH(WIDTH)) dut (
        .CK        (CK),
        .RST       (RST),
        .a_valid   (a_valid),
        .a_data    (a_data),
        .a_ready   (a_ready),
        .b_valid   (b_valid),
        .b_data    (b_data),
        .b_ready   (b_ready),
        .c_valid   (c_valid),
        .c_data    (c_data),
        .c_ready   (c_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .sel       (sel)
    );

    initial CK = 1'b0;
    always #5 CK = ~CK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One cycle: drive at negedge, check against the model, advance the model at posedge.
    task automatic step(input logic rst, input logic [2:0] v,
                        input logic [WIDTH-1:0] da, input logic [WIDTH-1:0] db,
                        input logic [WIDTH-1:0] dc, input logic ordy);
        logic [WIDTH-1:0] d [3];
        logic [2:0]       exp_rdy;
        logic [2:0]       exp_sel;
        logic             ld;
        int               win;
        @(negedge CK);
        RST = rst;
        a_valid = v[0]; b_valid = v[1]; c_valid = v[2];
        a_data = da; b_data = db; c_data = dc;
        out_ready = ordy;
        #1;
        d[0] = da; d[1] = db; d[2] = dc;
        ld  = !rst && (!m_valid || ordy) && (v != 3'b000);
        win = -1;
        if (ld) begin
            for (int k = 1; k <= 3; k++) begin
                int idx;
                idx = (m_last + k) % 3;
                if (win < 0 && v[idx]) win = idx;
            end
        end
        exp_rdy = (win >= 0) ? 3'(1 << win) : 3'b000;
        exp_sel = m_valid ? 3'(1 << m_src) : 3'b000;
        check("ready",     32'({c_ready, b_ready, a_ready}), 32'(exp_rdy));
        check("out_valid", 32'(out_valid), 32'(m_valid));
        check("out_data",  32'(out_data),  32'(m_data));
        check("sel",       32'(sel),       32'(exp_sel));
        if (rst) begin
            m_valid = 1'b0; m_data = '0; m_last = 2;
        end else if (win >= 0) begin
            m_valid = 1'b1; m_data = d[win]; m_src = win; m_last = win;
        end else if (m_valid && ordy) begin
            m_valid = 1'b0;
        end
        @(posedge CK);
    endtask

    // Directed spot check of the registered outputs just after an edge.
    task automatic peek(input string tag, input logic v, input logic [WIDTH-1:0] d,
                        input logic [2:0] s);
        #1;
        check({tag, "_valid"}, 32'(out_valid), 32'(v));
        check({tag, "_data"},  32'(out_data),  32'(d));
        check({tag, "_sel"},   32'(sel),       32'(s));
    endtask

    initial begin
        logic [WIDTH-1:0] rot_d [3];
        RST = 1'b1;
        a_valid = 1'b1; b_valid = 1'b1; c_valid = 1'b1;
        a_data = '0; b_data = '0; c_data = '0;
        out_ready = 1'b0;
        m_valid = 1'b0; m_data = '0; m_src = 0; m_last = 2;
        repeat (2) @(posedge CK);

        // Reset held with all sources requesting.
        repeat (2) step(1'b1, 3'b111, 8'h11, 8'h22, 8'h33, 1'b1);
        peek("reset", 1'b0, 8'h00, 3'b000);

        // Rotation A, B, C, A, ...
        rot_d[0] = 8'h11; rot_d[1] = 8'h22; rot_d[2] = 8'h33;
        for (int i = 0; i < 6; i++) begin
            step(1'b0, 3'b111, 8'h11, 8'h22, 8'h33, 1'b1);
            peek("rot", 1'b1, rot_d[i % 3], 3'(1 << (i % 3)));
        end

        // B alone, then A joins and wins next.
        repeat (4) begin
            step(1'b0, 3'b010, 8'h00, 8'h5A, 8'h00, 1'b1);
            peek("only_b", 1'b1, 8'h5A, 3'b010);
        end
        step(1'b0, 3'b011, 8'hA5, 8'h5A, 8'h00, 1'b1);
        peek("a_after_b", 1'b1, 8'hA5, 3'b001);

        // Load B's word, stall three cycles, then C wins.
        step(1'b0, 3'b111, 8'h11, 8'h22, 8'h33, 1'b1);
        peek("pre_stall", 1'b1, 8'h22, 3'b010);
        repeat (3) begin
            step(1'b0, 3'b111, 8'h11, 8'h22, 8'h33, 1'b0);
            peek("stall", 1'b1, 8'h22, 3'b010);
        end
        step(1'b0, 3'b111, 8'h11, 8'h22, 8'h33, 1'b1);
        peek("post_stall", 1'b1, 8'h33, 3'b100);

        // Drain to empty with no requesters.
        step(1'b0, 3'b000, 8'h00, 8'h00, 8'h00, 1'b1);
        peek("drain", 1'b0, 8'h33, 3'b000);

        // Reset while holding A's word; A is first again afterwards.
        step(1'b0, 3'b001, 8'h77, 8'h00, 8'h00, 1'b1);
        peek("pre_rst", 1'b1, 8'h77, 3'b001);
        step(1'b1, 3'b111, 8'h11, 8'h22, 8'h33, 1'b0);
        peek("mid_rst", 1'b0, 8'h00, 3'b000);
        step(1'b0, 3'b111, 8'h11, 8'h22, 8'h33, 1'b1);
        peek("after_rst", 1'b1, 8'h11, 3'b001);

        // Random traffic with occasional resets.
        for (int i = 0; i < 3000; i++) begin
            logic       r;
            logic [2:0] v;
            r = ($urandom_range(0, 99) < 2);
            v = 3'($urandom);
            step(r, v, 8'($urandom), 8'($urandom), 8'($urandom),
                 1'($urandom_range(0, 99) < 70));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
